// File: rtl/bitmap_pkg.sv
// Shared types and constants for the bitmap drawing engine.
package bitmap_pkg;

   localparam int unsigned SCREEN_W = 320;
   localparam int unsigned SCREEN_H = 240;
   localparam int unsigned X_W      = 9;
   localparam int unsigned Y_W      = 8;
   localparam int unsigned COLOR_W  = 3;

   typedef enum logic [1:0] {
      OP_PLOT  = 2'd0,
      OP_FILL  = 2'd1,
      OP_CLEAR = 2'd2,
      OP_NOP   = 2'd3
   } draw_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Effective raster bounds of an accepted command (inclusive corners).
   typedef struct packed {
      logic [X_W-1:0] x0;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] x1;
      logic [Y_W-1:0] y1;
   } draw_bounds_t;

endpackage

// File: rtl/bitmap_draw_ctrl_if.sv
// Command handshake plus bitmap write port of the drawing engine.
interface bitmap_draw_ctrl_if;
   import bitmap_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   draw_op_t             cmd_op;
   logic [X_W-1:0]       cmd_x0;
   logic [Y_W-1:0]       cmd_y0;
   logic [X_W-1:0]       cmd_x1;
   logic [Y_W-1:0]       cmd_y1;
   logic [COLOR_W-1:0]   cmd_color;
   logic [X_W-1:0]       x;
   logic [Y_W-1:0]       y;
   logic [COLOR_W-1:0]   color;
   logic                 wr_en;
   logic                 busy;
   logic                 done;

   modport master (
      output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      input  cmd_ready, x, y, color, wr_en, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      output cmd_ready, x, y, color, wr_en, busy, done
   );

endinterface

// File: rtl/bitmap_raster_counter.sv
// Loadable nested x/y raster counter; x is the inner loop. The x/y
// registers double as the bitmap write coordinates and hold between commands.
module bitmap_raster_counter
   import bitmap_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [X_W-1:0] x_start,
   input  logic [Y_W-1:0] y_start,
   input  logic [X_W-1:0] x_end,
   input  logic [Y_W-1:0] y_end,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last_c
);

   logic [X_W-1:0] x_base;
   logic [X_W-1:0] x_stop;
   logic [Y_W-1:0] y_stop;

   // Load bounds at accept, then walk the rectangle one pixel per step.
   always_ff @(posedge clk) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         x_base <= '0;
         x_stop <= '0;
         y_stop <= '0;
      end else if (load) begin
         x      <= x_start;
         y      <= y_start;
         x_base <= x_start;
         x_stop <= x_end;
         y_stop <= y_end;
      end else if (step) begin
         if (x == x_stop) begin
            x <= x_base;
            y <= y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

   // Equality against the latched corner, so x1=511 / y1=255 still terminate.
   assign last_c = (x == x_stop) && (y == y_stop);

endmodule

// File: rtl/bitmap_draw_ctrl.sv
// Command-driven pixel write sequencer for the 320x240 3-bit bitmap.
// Optional macro BITMAP_DRAW_CLIP_EN clips coordinates to the screen at accept.
module bitmap_draw_ctrl
   import bitmap_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   bitmap_draw_ctrl_if.slave  bus
);

   state_t             state;
   state_t             state_d;
   draw_bounds_t       bnd_c;
   logic               empty_c;
   logic               accept_c;
   logic               load_c;
   logic               step_c;
   logic               last_c;
   logic               cmd_ready;
   logic               wr_en;
   logic               busy;
   logic               done;
   logic [COLOR_W-1:0] color;
   logic [X_W-1:0]     cnt_x;
   logic [Y_W-1:0]     cnt_y;

   assign accept_c = bus.cmd_valid && (state == ST_IDLE);
   assign load_c   = accept_c && !empty_c;
   assign step_c   = (state == ST_DRAW) && !last_c;

   // Decode the command into raster bounds and flag zero-write commands.
   always_comb begin
      bnd_c.x0 = bus.cmd_x0;
      bnd_c.y0 = bus.cmd_y0;
      bnd_c.x1 = bus.cmd_x1;
      bnd_c.y1 = bus.cmd_y1;
      empty_c  = 1'b0;
      case (bus.cmd_op)
         OP_PLOT: begin
            bnd_c.x1 = bus.cmd_x0;
            bnd_c.y1 = bus.cmd_y0;
         end
         OP_FILL: begin
            empty_c = (bus.cmd_x1 < bus.cmd_x0) || (bus.cmd_y1 < bus.cmd_y0);
         end
         OP_CLEAR: begin
            bnd_c.x0 = '0;
            bnd_c.y0 = '0;
            bnd_c.x1 = X_W'(SCREEN_W - 1);
            bnd_c.y1 = Y_W'(SCREEN_H - 1);
         end
         default: begin
            empty_c = 1'b1;
         end
      endcase
`ifdef BITMAP_DRAW_CLIP_EN
      if (bnd_c.x1 > X_W'(SCREEN_W - 1)) bnd_c.x1 = X_W'(SCREEN_W - 1);
      if (bnd_c.y1 > Y_W'(SCREEN_H - 1)) bnd_c.y1 = Y_W'(SCREEN_H - 1);
      if ((bnd_c.x0 >= X_W'(SCREEN_W)) || (bnd_c.y0 >= Y_W'(SCREEN_H))) empty_c = 1'b1;
`else
      // Off-screen coordinates pass through; the caller keeps writes in range.
`endif
   end

   // Next-state logic: zero-write commands skip straight to FIN.
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (bus.cmd_valid) state_d = empty_c ? ST_FIN : ST_DRAW;
         ST_DRAW: if (last_c) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Registered handshake/strobe outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready <= 1'b1;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         color     <= '0;
      end else begin
         cmd_ready <= (state_d == ST_IDLE);
         wr_en     <= (state_d == ST_DRAW);
         busy      <= (state_d != ST_IDLE);
         done      <= (state_d == ST_FIN);
         if (load_c) color <= bus.cmd_color;
      end
   end

   bitmap_raster_counter u_raster (
      .clk     (clk),
      .reset   (reset),
      .load    (load_c),
      .step    (step_c),
      .x_start (bnd_c.x0),
      .y_start (bnd_c.y0),
      .x_end   (bnd_c.x1),
      .y_end   (bnd_c.y1),
      .x       (cnt_x),
      .y       (cnt_y),
      .last_c  (last_c)
   );

   assign bus.cmd_ready = cmd_ready;
   assign bus.wr_en     = wr_en;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.color     = color;
   assign bus.x         = cnt_x;
   assign bus.y         = cnt_y;

endmodule
